// File: rtl/sys_defs.sv
// Shared pipeline definitions: FU->RS result packet, CDB broadcast packet and default widths.
package sys_defs;

    localparam int unsigned DEFAULT_NUM_FU    = 4;
    localparam int unsigned DEFAULT_CDB_WIDTH = 2;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] NPC;
        logic [31:0] PC;
        logic [4:0]  dest_reg_idx;
        logic        take_branch;
        logic        is_branch;
        logic        halt;
        logic        illegal;
    } FU_RS_PACKET;

    typedef struct packed {
        logic [4:0]  dest_reg_idx;
        logic [31:0] alu_result;
        logic [31:0] NPC;
        logic [31:0] PC;
        logic        take_branch;
        logic        is_branch;
        logic        halt;
        logic        illegal;
    } CDB_PACKET;

    function automatic CDB_PACKET fu_to_cdb(input FU_RS_PACKET p);
        CDB_PACKET c;
        c.dest_reg_idx = p.dest_reg_idx;
        c.alu_result   = p.alu_result;
        c.NPC          = p.NPC;
        c.PC           = p.PC;
        c.take_branch  = p.take_branch;
        c.is_branch    = p.is_branch;
        c.halt         = p.halt;
        c.illegal      = p.illegal;
        return c;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: grants up to W requesters, scanning from start and wrapping.
module rr_pick_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 2,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]         req,
    input  logic [PTR_W-1:0]     start,
    output logic [W-1:0][N-1:0]  grant,
    output logic [PTR_W-1:0]     last_idx,
    output logic                 any_grant
);

    localparam int unsigned CNT_W  = $clog2(W + 1);
    localparam int unsigned LANE_W = (W > 1) ? $clog2(W) : 1;

    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        last_idx  = start;
        any_grant = 1'b0;
        cnt       = '0;
        idx       = '0;
        for (int unsigned o = 0; o < N; o++) begin
            idx = PTR_W'((32'(start) + o) % N);
            // Lane number equals the number of grants already issued this scan
            if (req[idx] && (32'(cnt) < W)) begin
                grant[cnt[LANE_W-1:0]][idx] = 1'b1;
                last_idx  = idx;
                any_grant = 1'b1;
                cnt       = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fu_result_collector.sv
// FU result collector: per-FU holding buffers, round-robin CDB arbitration, per-FU ack pulses.
// Optional stall statistics counter enabled by RESULT_COLLECTOR_STATS_EN.
module fu_result_collector
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU    = DEFAULT_NUM_FU,
    parameter int unsigned CDB_WIDTH = DEFAULT_CDB_WIDTH,
    parameter int unsigned PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [NUM_FU-1:0]             fu_result_valid,
    input  FU_RS_PACKET [NUM_FU-1:0]      fu_rs,
    input  logic                          cdb_ready,
    output logic [NUM_FU-1:0]             fu_ack,
    output logic [CDB_WIDTH-1:0]          cdb_valid,
    output CDB_PACKET [CDB_WIDTH-1:0]     cdb_packet,
    output logic [31:0]                   perf_stall_cycles
);

    FU_RS_PACKET [NUM_FU-1:0]            res_buf;
    logic [NUM_FU-1:0]                   buf_valid;
    logic [PTR_W-1:0]                    rr_ptr;
    logic [CDB_WIDTH-1:0][NUM_FU-1:0]    grant;
    logic [NUM_FU-1:0]                   granted;
    logic [NUM_FU-1:0]                   capture;
    logic [PTR_W-1:0]                    last_idx;
    logic                                any_grant;
    CDB_PACKET [CDB_WIDTH-1:0]           lane_pkt;

    rr_pick_n #(
        .N     (NUM_FU),
        .W     (CDB_WIDTH),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (cdb_ready ? buf_valid : '0),
        .start     (rr_ptr),
        .grant     (grant),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        granted  = '0;
        lane_pkt = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            granted = granted | grant[k];
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant[k][i]) lane_pkt[k] = fu_to_cdb(res_buf[i]);
            end
        end
        // The ~fu_ack term stops a held result from being captured twice
        capture = fu_result_valid & ~fu_ack & (~buf_valid | granted) & {NUM_FU{~squash}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_buf    <= '0;
            buf_valid  <= '0;
            rr_ptr     <= '0;
            fu_ack     <= '0;
            cdb_valid  <= '0;
            cdb_packet <= '0;
        end else if (squash) begin
            buf_valid  <= '0;
            rr_ptr     <= '0;
            fu_ack     <= '0;
            cdb_valid  <= '0;
            cdb_packet <= '0;
        end else begin
            fu_ack <= capture;
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i]) begin
                    res_buf[i]   <= fu_rs[i];
                    buf_valid[i] <= 1'b1;
                end else if (granted[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_valid[k]  <= |grant[k];
                cdb_packet[k] <= lane_pkt[k];
            end
            if (any_grant) rr_ptr <= PTR_W'((32'(last_idx) + 1) % NUM_FU);
        end
    end

`ifdef RESULT_COLLECTOR_STATS_EN
    logic stall;
    assign stall = (|buf_valid) && !any_grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
        end else if (stall && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fu_result_collector.sv
// Scoreboard bench for fu_result_collector: directed stimulus pushes expected CDB packets,
// a negedge monitor pops and compares them per lane.
module tb_fu_result_collector;
    import sys_defs::*;

    localparam int unsigned NF = 4;
    localparam int unsigned CW = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    logic [NF-1:0]           fu_result_valid;
    FU_RS_PACKET [NF-1:0]    fu_rs;
    logic                    cdb_ready;
    logic [NF-1:0]           fu_ack;
    logic [CW-1:0]           cdb_valid;
    CDB_PACKET [CW-1:0]      cdb_packet;
    logic [31:0]             perf_stall_cycles;

    fu_result_collector dut (
        .clock             (clock),
        .reset             (reset),
        .squash            (squash),
        .fu_result_valid   (fu_result_valid),
        .fu_rs             (fu_rs),
        .cdb_ready         (cdb_ready),
        .fu_ack            (fu_ack),
        .cdb_valid         (cdb_valid),
        .cdb_packet        (cdb_packet),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clock = ~clock;

    CDB_PACKET exp_q[$];
    CDB_PACKET mon_e;
    int n_pass   = 0;
    int n_total  = 0;
    int sb_pass  = 0;
    int sb_total = 0;
    logic [31:0] p0;

    function automatic FU_RS_PACKET mk_fu(input logic [4:0] d, input logic [31:0] v,
                                          input logic hf, input logic il);
        FU_RS_PACKET p;
        p.alu_result   = v;
        p.PC           = {v[15:0], 16'h0040};
        p.NPC          = {v[15:0], 16'h0044};
        p.dest_reg_idx = d;
        p.take_branch  = v[0];
        p.is_branch    = v[1];
        p.halt         = hf;
        p.illegal      = il;
        return p;
    endfunction

    function automatic CDB_PACKET mk_cdb(input logic [4:0] d, input logic [31:0] v,
                                         input logic hf, input logic il);
        CDB_PACKET c;
        c.dest_reg_idx = d;
        c.alu_result   = v;
        c.PC           = {v[15:0], 16'h0040};
        c.NPC          = {v[15:0], 16'h0044};
        c.take_branch  = v[0];
        c.is_branch    = v[1];
        c.halt         = hf;
        c.illegal      = il;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every valid lane must match the next expected packet; idle lanes carry zero.
    always @(negedge clock) begin
        if (reset) begin
            for (int k = 0; k < CW; k++) begin
                sb_total++;
                if (cdb_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected lane%0d: got %h expected none",
                                 k, cdb_packet[k]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (cdb_packet[k] == mon_e) sb_pass++;
                        else $display("FAIL sb_lane%0d: got %h expected %h",
                                      k, cdb_packet[k], mon_e);
                    end
                end else if (cdb_packet[k] == '0) begin
                    sb_pass++;
                end else begin
                    $display("FAIL sb_idle_lane%0d: got %h expected 0", k, cdb_packet[k]);
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        squash          = 1'b0;
        cdb_ready       = 1'b1;
        fu_result_valid = '0;
        fu_rs           = '0;
        tick();
        tick();
        chk("rst_ack", 64'(fu_ack), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_perf", 64'(perf_stall_cycles), 64'h0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        reset = 1'b1;
        tick();

        // Contention: all four FUs at once, two lanes per cycle, FU0/FU1 then FU2/FU3
        for (int i = 0; i < 4; i++) begin
            fu_rs[i] = mk_fu(5'(10 + i), 32'hA000 + 32'(i), 1'b0, 1'b0);
            exp_q.push_back(mk_cdb(5'(10 + i), 32'hA000 + 32'(i), 1'b0, 1'b0));
        end
        fu_result_valid = 4'hF;
        tick();
        chk("cont_ack", 64'(fu_ack), 64'hF);
        chk("cont_cdb_t1", 64'(cdb_valid), 64'h0);
        fu_result_valid = '0;
        tick();
        chk("cont_cdb_t2", 64'(cdb_valid), 64'h3);
        chk("cont_rr_mid", 64'(dut.rr_ptr), 64'h2);
        tick();
        chk("cont_cdb_t3", 64'(cdb_valid), 64'h3);
        chk("cont_rr_end", 64'(dut.rr_ptr), 64'h0);
        tick();
        chk("cont_drain", 64'(cdb_valid), 64'h0);

        // Single result on FU1
        fu_rs[1] = mk_fu(5'd5, 32'h1234, 1'b0, 1'b0);
        exp_q.push_back(mk_cdb(5'd5, 32'h1234, 1'b0, 1'b0));
        fu_result_valid = 4'b0010;
        tick();
        chk("single_ack", 64'(fu_ack), 64'h2);
        chk("single_cdb_t1", 64'(cdb_valid), 64'h0);
        fu_result_valid = '0;
        tick();
        chk("single_cdb_t2", 64'(cdb_valid), 64'h1);
        chk("single_ack_gone", 64'(fu_ack), 64'h0);
        chk("single_rr", 64'(dut.rr_ptr), 64'h2);
        tick();

        // Backpressure: FU2 held three cycles; halt flag passes through untouched
        cdb_ready = 1'b0;
        fu_rs[2] = mk_fu(5'd9, 32'hBEEF, 1'b1, 1'b0);
        exp_q.push_back(mk_cdb(5'd9, 32'hBEEF, 1'b1, 1'b0));
        fu_result_valid = 4'b0100;
        tick();
        fu_result_valid = '0;
        p0 = perf_stall_cycles;
        for (int c = 0; c < 3; c++) begin
            chk("bp_cdb_held", 64'(cdb_valid), 64'h0);
            chk("bp_buf_held", 64'(dut.buf_valid), 64'h4);
            tick();
        end
        cdb_ready = 1'b1;
        tick();
        chk("bp_release", 64'(cdb_valid), 64'h1);
        chk("bp_rr", 64'(dut.rr_ptr), 64'h3);
`ifdef RESULT_COLLECTOR_STATS_EN
        chk("bp_stall_count", 64'(perf_stall_cycles - p0), 64'h3);
`else
        chk("bp_stall_tied", 64'(perf_stall_cycles), 64'h0);
`endif
        tick();

        // Back-to-back on FU0: B captured on the edge that grants A
        cdb_ready = 1'b0;
        fu_rs[0] = mk_fu(5'd7, 32'h0000_AAAA, 1'b0, 1'b1);
        exp_q.push_back(mk_cdb(5'd7, 32'h0000_AAAA, 1'b0, 1'b1));
        exp_q.push_back(mk_cdb(5'd8, 32'h0000_BBBB, 1'b0, 1'b0));
        fu_result_valid = 4'b0001;
        tick();
        chk("b2b_ack_a", 64'(fu_ack), 64'h1);
        fu_rs[0] = mk_fu(5'd8, 32'h0000_BBBB, 1'b0, 1'b0);
        tick();
        chk("b2b_no_dbl", 64'(fu_ack), 64'h0);
        cdb_ready = 1'b1;
        tick();
        chk("b2b_cdb_a", 64'(cdb_valid), 64'h1);
        chk("b2b_ack_b", 64'(fu_ack), 64'h1);
        chk("b2b_rr", 64'(dut.rr_ptr), 64'h1);
        fu_result_valid = '0;
        tick();
        chk("b2b_cdb_b", 64'(cdb_valid), 64'h1);
        tick();
        chk("b2b_no_dup", 64'(cdb_valid), 64'h0);

        // Squash with FU1/FU3 buffered and FU0 arriving
        cdb_ready = 1'b0;
        fu_rs[1] = mk_fu(5'd1, 32'h1111, 1'b0, 1'b0);
        fu_rs[3] = mk_fu(5'd3, 32'h3333, 1'b0, 1'b0);
        fu_result_valid = 4'b1010;
        tick();
        chk("sq_ack_pre", 64'(fu_ack), 64'hA);
        fu_result_valid = 4'b0001;
        fu_rs[0] = mk_fu(5'd2, 32'h2222, 1'b0, 1'b0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("sq_buf", 64'(dut.buf_valid), 64'h0);
        chk("sq_cdb", 64'(cdb_valid), 64'h0);
        chk("sq_ack", 64'(fu_ack), 64'h0);
        chk("sq_rr", 64'(dut.rr_ptr), 64'h0);
        fu_result_valid = '0;
        cdb_ready = 1'b1;
        tick();
        tick();
        chk("sq_no_bcast", 64'(cdb_valid), 64'h0);
        chk("sq_q_empty", 64'(exp_q.size()), 64'h0);

        // Async reset mid-broadcast; these packets are discarded, so none are expected
        fu_rs[2] = mk_fu(5'd4, 32'h4444, 1'b0, 1'b0);
        fu_result_valid = 4'b0100;
        tick();
        fu_result_valid = 4'b0001;
        fu_rs[0] = mk_fu(5'd6, 32'h6666, 1'b0, 1'b0);
        tick();
        chk("ar_pre_cdb", 64'(cdb_valid), 64'h1);
        chk("ar_pre_ack", 64'(fu_ack), 64'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_cdb_drop", 64'(cdb_valid), 64'h0);
        chk("ar_ack_drop", 64'(fu_ack), 64'h0);
        fu_result_valid = '0;
        tick();
        reset = 1'b1;
        chk("ar_perf", 64'(perf_stall_cycles), 64'h0);
        fu_rs[3] = mk_fu(5'd12, 32'hC0DE, 1'b0, 1'b0);
        exp_q.push_back(mk_cdb(5'd12, 32'hC0DE, 1'b0, 1'b0));
        fu_result_valid = 4'b1000;
        tick();
        chk("ar_post_ack", 64'(fu_ack), 64'h8);
        chk("ar_post_cdb_t1", 64'(cdb_valid), 64'h0);
        fu_result_valid = '0;
        tick();
        chk("ar_post_cdb_t2", 64'(cdb_valid), 64'h1);
        chk("ar_post_rr", 64'(dut.rr_ptr), 64'h0);
        tick();
        tick();
        chk("final_q_empty", 64'(exp_q.size()), 64'h0);

        n_pass  += sb_pass;
        n_total += sb_total;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
